afu_port_flr_sequencer: RTL
===========================

Name: afu_port_flr_sequencer

Overview:
- Shared reset engine for the static-region AFU ports.
- Receives per-port function-level reset requests, already decoded from PF/VF FLR through the routing table.
- Selects one pending port at a time by round-robin, then sequences that port: fence new TX packets at a packet boundary, drain, hold reset, release, report done.
- Sits between the FLR reset manager and the per-port AFU instances, alongside the A-side PF/VF mux.

Parameters:
- NUM_PORTS, 8, number of AFU ports sequenced (1..32).
- RST_HOLD_CYCLES, 16, cycles port_rst is held asserted (>=1).
- DRAIN_TIMEOUT, 1024, max cycles to wait for a packet boundary before forcing reset (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- func_rst_req  in  NUM_PORTS  level request per port; held high until flr_done is seen.
- tx_tvalid  in  NUM_PORTS  per-port AFU TX A tvalid (monitor only).
- tx_tready  in  NUM_PORTS  per-port TX A tready from the mux (monitor only).
- tx_tlast  in  NUM_PORTS  per-port TX A tlast (monitor only).
- tx_block  out  NUM_PORTS  when high, the wrapper forces the port's tvalid and tready to 0.
- port_rst  out  NUM_PORTS  active-high reset to the AFU instance, OR'd with system reset externally.
- flr_done  out  NUM_PORTS  one-cycle pulse when the port's sequence completes.
- drain_timeout_err  out  NUM_PORTS  sticky; set when a port was reset by forced timeout.
- busy  out  1  engine not IDLE.

Behaviour:
- Reset values: tx_block=0, port_rst=0, flr_done=0, drain_timeout_err=0, busy=0, in_pkt=0, rr pointer=0, state=IDLE.
- in_pkt[p] (per-port tracker):
  - Set on tvalid&tready&~tlast.
  - Cleared on tvalid&tready&tlast.
  - Forced to 0 while port_rst[p]=1.
  - A single-beat packet (tlast on the first beat) leaves in_pkt at 0.
- pending[p] = func_rst_req[p] & ~armed_block[p]. armed_block[p] is set at flr_done[p] and cleared when func_rst_req[p]=0. One request therefore produces exactly one sequence.
- Round-robin: search starts at the port after the last-served port. Index wraps NUM_PORTS-1 -> 0.
- IDLE:
  - If any pending: latch sel = RR winner, clear the timer, go to FENCE on the next cycle.
  - Arbitration is evaluated only in IDLE. A request arriving mid-sequence waits.
- FENCE:
  - fence_sel=1 for sel.
  - tx_block[sel] = fence_sel & ~in_pkt[sel] (combinational on in_pkt). This never cuts a packet mid-flight; the in-flight packet is allowed to finish.
  - Timer increments each cycle.
  - If in_pkt[sel]=0, go to RESET.
  - Else if timer == DRAIN_TIMEOUT-1, set drain_timeout_err[sel] and go to RESET (forced).
  - Packet completion and timeout in the same cycle: treated as clean completion; error not set.
- RESET:
  - tx_block[sel]=1 and port_rst[sel]=1, registered: asserted the cycle after entry.
  - Held exactly RST_HOLD_CYCLES cycles, then go to RELEASE.
- RELEASE (1 cycle):
  - port_rst[sel]=0 and tx_block[sel]=0.
  - flr_done[sel] pulses.
  - Update the rr last-served pointer to sel.
  - Go to IDLE.
- Minimum latency, request to flr_done: 1 (IDLE) + 1 (FENCE with in_pkt=0) + RST_HOLD_CYCLES + 1 cycles. This is 19 at defaults.
- Request withdrawn mid-sequence: the sequence still completes, including the done pulse.
- rst during any state: all outputs return to reset values in the next cycle. Any port in reset is released immediately and no flr_done is issued. The requester re-requests by holding func_rst_req, because armed_block is also cleared.
- Ports other than sel: tx_block=0 and port_rst=0 at all times.
- Only one bit of port_rst and one bit of flr_done is ever high at a time.
- Timer width is $clog2(max(DRAIN_TIMEOUT, RST_HOLD_CYCLES))+1 bits and is shared by FENCE and RESET.

Decomposition:
- New package afu_flr_seq_pkg holds:
  - t_flr_seq_state enum {IDLE, FENCE, RESET, RELEASE};
  - a localparam function for the timer width.
- Natural sub-module: axis_pkt_boundary_tracker, one instance per port, producing in_pkt[p].
- FSM, round-robin arbiter and timer stay in the top module.

Test Plan:
- Single clean request: port 2 requests with its link idle -> tx_block[2] high from cycle 1; port_rst[2] high for 16 cycles; flr_done[2] pulses at cycle 18 counted from request; drain_timeout_err=0.
- Mid-packet drain: port 1 is in beat 2 of a 5-beat packet when it requests -> tx_block[1] stays 0 until the tlast handshake; port_rst rises the cycle after FENCE exits; no beats are lost.
- Timeout: DRAIN_TIMEOUT=8, port 3 holds in_pkt with tready=0 -> RESET is forced 8 cycles after FENCE entry; drain_timeout_err[3]=1 and stays sticky until rst.
- Round-robin fairness: ports 0, 5 and 7 request in the same cycle with last-served=5 -> service order 7, 0, 5; only one port_rst bit high at any time.
- No re-trigger: port 4 holds func_rst_req for 100 cycles -> exactly one flr_done[4]; after a deassert/reassert a second sequence runs.
- Reset mid-RESET: assert rst at cycle 10 of port 6's hold -> the next cycle port_rst=0, tx_block=0, busy=0, and no flr_done.

Source files
------------

// File: rtl/afu_flr_seq_pkg.sv
// rtl/afu_flr_seq_pkg.sv - shared types and helpers for the AFU port FLR sequencer
// Purpose: FSM state encoding and the width helper for the shared drain/hold timer.
// Ports: none (package).
package afu_flr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FENCE   = 2'd1,
    RESET   = 2'd2,
    RELEASE = 2'd3
  } t_flr_seq_state;

  // One timer serves both the drain wait and the reset hold, so it is sized
  // for the larger terminal count with one spare bit.
  function automatic int flr_timer_width(input int drain_timeout, input int hold_cycles);
    int max_count;
    max_count = (drain_timeout > hold_cycles) ? drain_timeout : hold_cycles;
    return $clog2(max_count) + 1;
  endfunction

endpackage

// File: rtl/axis_pkt_boundary_tracker.sv
// rtl/axis_pkt_boundary_tracker.sv - tracks whether one stream port is mid-packet
// Purpose: o_in_pkt is high between the first and the tlast handshake of a packet.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_port_rst          per-port reset; clears the tracker while high
//   i_tvalid/i_tready   handshake monitored on the port
//   i_tlast             last beat marker
//   o_in_pkt            a packet has started and its tlast beat has not been accepted
module axis_pkt_boundary_tracker (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_port_rst,
  input  logic i_tvalid,
  input  logic i_tready,
  input  logic i_tlast,
  output logic o_in_pkt
);

  logic r_in_pkt;

  // A single-beat packet (tlast on the first beat) leaves the tracker at 0.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_port_rst) begin
      r_in_pkt <= 1'b0;
    end else if (i_tvalid && i_tready) begin
      r_in_pkt <= ~i_tlast;
    end
  end

  assign o_in_pkt = r_in_pkt;

endmodule

// File: rtl/afu_port_flr_sequencer.sv
// rtl/afu_port_flr_sequencer.sv - round-robin function-level reset engine for AFU ports
// Purpose: picks one pending port at a time, fences its TX at a packet boundary,
//          holds it in reset, releases it and pulses flr_done.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_func_rst_req          per-port level request, held until flr_done
//   i_tx_tvalid/tready/tlast per-port TX monitor inputs
//   o_tx_block              wrapper forces the port's tvalid/tready low
//   o_port_rst              reset to the AFU instance
//   o_flr_done              one-cycle completion pulse
//   o_drain_timeout_err     sticky: port reset was forced by drain timeout
//   o_busy                  engine not idle
module afu_port_flr_sequencer
  import afu_flr_seq_pkg::*;
#(
  parameter int NUM_PORTS       = 8,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int DRAIN_TIMEOUT   = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_PORTS-1:0] i_func_rst_req,
  input  logic [NUM_PORTS-1:0] i_tx_tvalid,
  input  logic [NUM_PORTS-1:0] i_tx_tready,
  input  logic [NUM_PORTS-1:0] i_tx_tlast,
  output logic [NUM_PORTS-1:0] o_tx_block,
  output logic [NUM_PORTS-1:0] o_port_rst,
  output logic [NUM_PORTS-1:0] o_flr_done,
  output logic [NUM_PORTS-1:0] o_drain_timeout_err,
  output logic                 o_busy
);

  localparam int TW = flr_timer_width(DRAIN_TIMEOUT, RST_HOLD_CYCLES);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  t_flr_seq_state       r_state;
  t_flr_seq_state       w_state_nxt;
  logic [PW-1:0]        r_sel;
  logic [PW-1:0]        r_last;
  logic [PW-1:0]        w_grant;
  logic                 w_grant_vld;
  logic [TW-1:0]        r_timer;
  logic [NUM_PORTS-1:0] w_in_pkt;
  logic [NUM_PORTS-1:0] r_armed;
  logic [NUM_PORTS-1:0] w_pending;
  logic [NUM_PORTS-1:0] w_sel_onehot;
  logic [NUM_PORTS-1:0] r_port_rst;
  logic [NUM_PORTS-1:0] r_drain_err;
  logic                 w_sel_in_pkt;
  logic                 w_sel_last_beat;
  logic                 w_fence_timeout;
  logic                 w_hold_done;

  genvar g;
  generate
    for (g = 0; g < NUM_PORTS; g++) begin : g_trk
      axis_pkt_boundary_tracker u_trk (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_port_rst (r_port_rst[g]),
        .i_tvalid   (i_tx_tvalid[g]),
        .i_tready   (i_tx_tready[g]),
        .i_tlast    (i_tx_tlast[g]),
        .o_in_pkt   (w_in_pkt[g])
      );
    end
  endgenerate

  // armed blocks a still-held request from starting a second sequence.
  assign w_pending       = i_func_rst_req & ~r_armed;
  assign w_sel_onehot    = NUM_PORTS'(1) << r_sel;
  assign w_sel_in_pkt    = w_in_pkt[r_sel];
  assign w_sel_last_beat = i_tx_tvalid[r_sel] & i_tx_tready[r_sel] & i_tx_tlast[r_sel];
  assign w_fence_timeout = (r_timer == TW'(DRAIN_TIMEOUT - 1));
  assign w_hold_done     = (r_timer == TW'(RST_HOLD_CYCLES - 1));

  // Round-robin: search starts one past the last-served port and wraps.
  always_comb begin : rr_arb
    int            v_k;
    logic [PW-1:0] v_idx;
    w_grant     = '0;
    w_grant_vld = 1'b0;
    v_k         = 0;
    v_idx       = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      v_k = int'(r_last) + i;
      if (v_k >= NUM_PORTS) begin
        v_k = v_k - NUM_PORTS;
      end
      v_idx = PW'(v_k);
      if (!w_grant_vld && w_pending[v_idx]) begin
        w_grant     = v_idx;
        w_grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant_vld) w_state_nxt = FENCE;
      FENCE:   if (!w_sel_in_pkt || w_fence_timeout) w_state_nxt = RESET;
      RESET:   if (w_hold_done) w_state_nxt = RELEASE;
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_last      <= '0;
      r_timer     <= '0;
      r_armed     <= '0;
      r_port_rst  <= '0;
      r_drain_err <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_armed    <= (r_armed & i_func_rst_req) | o_flr_done;
      r_port_rst <= (w_state_nxt == RESET) ? w_sel_onehot : '0;
      if (r_state == IDLE && w_grant_vld) begin
        r_sel <= w_grant;
      end
      if (r_state == RELEASE) begin
        r_last <= r_sel;
      end
      // Timer restarts on every state change so FENCE and RESET each count from 0.
      if (r_state == IDLE || r_state != w_state_nxt) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + 1'b1;
      end
      // A tlast handshake landing on the timeout cycle counts as a clean drain.
      if (r_state == FENCE && w_sel_in_pkt && w_fence_timeout && !w_sel_last_beat) begin
        r_drain_err <= r_drain_err | w_sel_onehot;
      end
    end
  end

  // In FENCE the block follows in_pkt so an in-flight packet can finish.
  assign o_tx_block = w_sel_onehot &
                      {NUM_PORTS{(r_state == FENCE && !w_sel_in_pkt) || r_state == RESET}};
  assign o_port_rst          = r_port_rst;
  assign o_flr_done          = w_sel_onehot & {NUM_PORTS{r_state == RELEASE}};
  assign o_drain_timeout_err = r_drain_err;
  assign o_busy              = (r_state != IDLE);

endmodule
